fetch: RTL and testbench

- Instruction fetch unit; the producer of the 8-bit instruction byte that the controller decodes into opcode[7:4] / operand[3:0].
- Holds the program counter (PC) and reads program memory over a req/ack handshake.
- Presents each fetched instruction to the controller over a valid/ready handshake.
- Accepts a jump redirect from the controller, which flushes any fetch in progress.

---
 rtl/fetch_if.sv | 37 +++
 rtl/fetch.sv | 138 +++++++++++++
 tb/tb_fetch.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Interface bundling the fetch unit's program-memory read port and its
// instruction hand-off to the controller. The master side is the fetch unit.
interface fetch_if #(
  parameter int ADDR_W = 8
);
  // Program-memory read channel (req/ack)
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_ack;
  logic [7:0]        mem_data;

  // Instruction channel to the controller (valid/ready)
  logic [7:0]        instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  // Redirect from the controller
  logic              jmp_en;
  logic [ADDR_W-1:0] jmp_addr;

  modport master (
    output mem_addr, mem_req,
    input  mem_ack, mem_data,
    output instr, instr_pc, instr_valid,
    input  instr_ready,
    input  jmp_en, jmp_addr
  );

  modport slave (
    input  mem_addr, mem_req,
    output mem_ack, mem_data,
    input  instr, instr_pc, instr_valid,
    output instr_ready,
    output jmp_en, jmp_addr
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch unit: holds the PC, reads program memory over req/ack and
// hands each byte to the controller over valid/ready. A jump redirect flushes
// whatever is in flight. Define FETCH_PREFETCH_EN to add a one-entry prefetch
// buffer so the memory can be kept busy while the controller holds off.
module fetch #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);

  typedef enum logic {
    REQ,
    HOLD
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic [7:0]        instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              ack_ok;

`ifdef FETCH_PREFETCH_EN
  logic [7:0]        pbuf;
  logic [ADDR_W-1:0] pbuf_pc;
  logic              pbuf_valid;
`endif

  // Wraps silently at the top of the address space.
  assign pc_inc = pc + ADDR_W'(1);

  // An ack only means something while our own request is still up.
  assign ack_ok = mem_req & bus.mem_ack;

  assign bus.mem_addr    = mem_addr;
  assign bus.mem_req     = mem_req;
  assign bus.instr       = instr;
  assign bus.instr_pc    = instr_pc;
  assign bus.instr_valid = instr_valid;

  // Fetch state machine: reset, then jump redirect, then the REQ/HOLD flow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= REQ;
      pc          <= RESET_VEC;
      mem_addr    <= RESET_VEC;
      mem_req     <= 1'b0;
      instr       <= 8'h00;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      pbuf        <= 8'h00;
      pbuf_pc     <= '0;
      pbuf_valid  <= 1'b0;
`endif
    end else if (bus.jmp_en) begin
      // A same-cycle ack is dropped; a same-cycle transfer already happened.
      state       <= REQ;
      pc          <= bus.jmp_addr;
      mem_addr    <= bus.jmp_addr;
      mem_req     <= 1'b1;
      instr_valid <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      pbuf_valid  <= 1'b0;
`endif
    end else begin
      case (state)
        REQ: begin
          if (ack_ok) begin
            instr       <= bus.mem_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc_inc;
            mem_addr    <= pc_inc;
            state       <= HOLD;
`ifdef FETCH_PREFETCH_EN
            mem_req     <= 1'b1;
`else
            mem_req     <= 1'b0;
`endif
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= pc;
          end
        end

        HOLD: begin
`ifdef FETCH_PREFETCH_EN
          if (bus.instr_ready) begin
            if (pbuf_valid) begin
              instr      <= pbuf;
              instr_pc   <= pbuf_pc;
              pbuf_valid <= 1'b0;
              mem_req    <= 1'b1;
              mem_addr   <= pc;
            end else if (ack_ok) begin
              instr    <= bus.mem_data;
              instr_pc <= pc;
              pc       <= pc_inc;
              mem_addr <= pc_inc;
              mem_req  <= 1'b1;
            end else begin
              instr_valid <= 1'b0;
              mem_req     <= 1'b1;
              mem_addr    <= pc;
              state       <= REQ;
            end
          end else if (ack_ok) begin
            pbuf       <= bus.mem_data;
            pbuf_pc    <= pc;
            pbuf_valid <= 1'b1;
            pc         <= pc_inc;
            mem_addr   <= pc_inc;
            mem_req    <= 1'b0;
          end else if (!pbuf_valid) begin
            mem_req  <= 1'b1;
            mem_addr <= pc;
          end
`else
          if (bus.instr_ready) begin
            instr_valid <= 1'b0;
            mem_req     <= 1'b1;
            mem_addr    <= pc;
            state       <= REQ;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch. A main instance (ADDR_W=8) is driven by a
// programmable-latency memory model and scored against a queue of expected
// instructions; a second instance (ADDR_W=4) exercises PC wrap-around.
module tb_fetch;

  logic clk;
  logic rst;

  fetch_if #(.ADDR_W(8)) bus ();
  fetch_if #(.ADDR_W(4)) sbus ();

  fetch #(.ADDR_W(8), .RESET_VEC(8'h00)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  fetch #(.ADDR_W(4), .RESET_VEC(4'h0)) u_small (
    .clk(clk),
    .rst(rst),
    .bus(sbus)
  );

`ifdef FETCH_PREFETCH_EN
  localparam int EXP_GAP        = 1;
  localparam int EXP_STALL_ACKS = 1;
`else
  localparam int EXP_GAP        = 3;
  localparam int EXP_STALL_ACKS = 0;
`endif

  typedef struct {
    logic [7:0] pc;
    logic [7:0] data;
  } sb_t;

  sb_t        sb_q[$];
  sb_t        sb_e;
  logic [7:0] exp_addr;
  logic       req_hold;
  int         n_checks;
  int         n_pass;
  int         n_acks;
  int         n_xfers;
  int         mem_lat;
  int         wait_cnt;

  // Program memory contents for the main instance.
  function automatic logic [7:0] rom(input logic [7:0] a);
    case (a)
      8'h00:   rom = 8'h12;
      8'h01:   rom = 8'h34;
      default: rom = a ^ 8'h5A;
    endcase
  endfunction

  // Program memory contents for the 4-bit instance.
  function automatic logic [7:0] rom4(input logic [3:0] a);
    case (a)
      4'hF:    rom4 = 8'hA1;
      4'h0:    rom4 = 8'hB2;
      default: rom4 = {4'h0, a};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic ready, input logic jmp, input logic [7:0] jaddr);
    bus.instr_ready = ready;
    bus.jmp_en      = jmp;
    bus.jmp_addr    = jaddr;
  endtask

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: acks once the request has been up for mem_lat cycles; with
  // mem_lat=1 it keeps acking every cycle the request stays up.
  always @(posedge clk) begin
    if (rst || !bus.mem_req) wait_cnt <= 0;
    else if (bus.mem_ack) wait_cnt <= (mem_lat > 1) ? 0 : wait_cnt;
    else wait_cnt <= wait_cnt + 1;
  end

  assign bus.mem_ack  = bus.mem_req && (wait_cnt >= mem_lat);
  assign bus.mem_data = rom(bus.mem_addr);

  // The 4-bit instance sees a zero-latency memory and an always-ready consumer.
  assign sbus.mem_ack     = sbus.mem_req;
  assign sbus.mem_data    = rom4(sbus.mem_addr);
  assign sbus.instr_ready = 1'b1;

  // Scoreboard: predict fetch addresses, push acked reads, pop on transfers.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      sb_q.delete();
      exp_addr = 8'h00;
      req_hold = 1'b0;
    end else begin
      if (bus.mem_req) checkOutput("mem_addr", bus.mem_addr, exp_addr);
      if (req_hold) checkOutput("req_held", bus.mem_req, 1);
      if (bus.instr_valid && bus.instr_ready) begin
        n_xfers++;
        checkOutput("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          sb_e = sb_q.pop_front();
          checkOutput("instr", bus.instr, sb_e.data);
          checkOutput("instr_pc", bus.instr_pc, sb_e.pc);
        end
      end
      if (bus.jmp_en) begin
        sb_q.delete();
        exp_addr = bus.jmp_addr;
      end else if (bus.mem_req && bus.mem_ack) begin
        sb_q.push_back('{pc: exp_addr, data: rom(exp_addr)});
        exp_addr = exp_addr + 8'h01;
        n_acks++;
      end
      req_hold = bus.mem_req && !bus.mem_ack && !bus.jmp_en;
    end
  end

  // Directed phases
  initial begin
    int cyc;
    int t0;
    int a0;
    int x0;
    logic [7:0] spc[2];
    logic [7:0] sdat[2];
    int sn;

    n_checks = 0;
    n_pass   = 0;
    n_acks   = 0;
    n_xfers  = 0;
    mem_lat  = 1;
    exp_addr = 8'h00;
    req_hold = 1'b0;
    rst      = 1'b1;
    sbus.jmp_en   = 1'b0;
    sbus.jmp_addr = 4'h0;
    applyStimulus(1'b1, 1'b0, 8'h00);

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", bus.instr_valid, 0);
    checkOutput("rst_req", bus.mem_req, 0);
    checkOutput("rst_addr", bus.mem_addr, 8'h00);
    checkOutput("rst_instr", bus.instr, 8'h00);
    checkOutput("rst_pc", bus.instr_pc, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("first_req", bus.mem_req, 1);
    checkOutput("first_addr", bus.mem_addr, 8'h00);

    // First two instructions and the spacing between them
    cyc = 0;
    while (!(bus.instr_valid && bus.instr_ready) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("first_xfer_seen", cyc < 40, 1);
    checkOutput("first_instr", bus.instr, 8'h12);
    checkOutput("first_instr_pc", bus.instr_pc, 8'h00);
    t0 = cyc;
    @(negedge clk);
    cyc++;
    while (!(bus.instr_valid && bus.instr_ready) && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("second_xfer_seen", cyc < 80, 1);
    checkOutput("second_instr", bus.instr, 8'h34);
    checkOutput("second_instr_pc", bus.instr_pc, 8'h01);
    checkOutput("valid_gap", cyc - t0, EXP_GAP);

    // Stall the consumer for 5 cycles
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 8'h00);
    cyc = 0;
    while (!bus.instr_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("stall_valid_seen", cyc < 40, 1);
    a0 = n_acks;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", bus.instr_valid, 1);
      if (sb_q.size() != 0) checkOutput("stall_instr", bus.instr, sb_q[0].data);
      if (i > 0) checkOutput("stall_req", bus.mem_req, 0);
      @(negedge clk);
    end
    checkOutput("stall_acks", n_acks - a0, EXP_STALL_ACKS);

    // Reset while holding an instruction
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_valid", bus.instr_valid, 0);
    checkOutput("midrst_req", bus.mem_req, 0);
    checkOutput("midrst_addr", bus.mem_addr, 8'h00);
    checkOutput("midrst_instr", bus.instr, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postrst_req", bus.mem_req, 1);
    checkOutput("postrst_addr", bus.mem_addr, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);

    // Jump in the same cycle as the ack for address 5
    cyc = 0;
    while (!(bus.mem_req && bus.mem_ack && bus.mem_addr == 8'h05) && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("ack5_seen", cyc < 60, 1);
    applyStimulus(1'b1, 1'b1, 8'h20);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("jmp_req", bus.mem_req, 1);
    checkOutput("jmp_addr", bus.mem_addr, 8'h20);
    cyc = 0;
    while (!(bus.instr_valid && bus.instr_ready) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("jmp_xfer_seen", cyc < 40, 1);
    checkOutput("jmp_instr_pc", bus.instr_pc, 8'h20);
    checkOutput("jmp_instr", bus.instr, rom(8'h20));

    // Slow memory with a ragged consumer
    @(negedge clk);
    mem_lat = 3;
    x0 = n_xfers;
    for (int i = 0; i < 60; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 1'b0, 8'h00);
      @(negedge clk);
    end
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("slow_progress", (n_xfers - x0) > 3, 1);
    mem_lat = 1;
    repeat (4) @(negedge clk);

    // Wrap-around on the 4-bit instance
    sbus.jmp_en   = 1'b1;
    sbus.jmp_addr = 4'hF;
    @(negedge clk);
    sbus.jmp_en = 1'b0;
    sn = 0;
    for (int i = 0; i < 20 && sn < 2; i++) begin
      if (sbus.instr_valid) begin
        spc[sn]  = {4'h0, sbus.instr_pc};
        sdat[sn] = sbus.instr;
        sn++;
      end
      @(negedge clk);
    end
    checkOutput("wrap_count", sn, 2);
    checkOutput("wrap_pc0", spc[0], 8'h0F);
    checkOutput("wrap_instr0", sdat[0], 8'hA1);
    checkOutput("wrap_pc1", spc[1], 8'h00);
    checkOutput("wrap_instr1", sdat[1], 8'hB2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
